// File: rtl/spi_flash_reader.sv
// SPI mode-0 master that issues a flash READ (0x03) for LEN bytes and streams them
// to a valid/ready consumer, holding SCK low whenever the consumer falls behind.
module spi_flash_reader #(
    parameter int CLK_DIV = 2,
    parameter int ADDR_W  = 24,
    parameter int LEN_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic [7:0]        byte_data,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic              spi_cs_n,
    output logic              spi_sck,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic [2:0]        dbg_state_o
);

    // Byte interface: a byte transfers on any clk edge where byte_valid && byte_ready;
    // byte_data and byte_valid hold their values until that edge.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CMD    = 3'd1,
        S_ADDR   = 3'd2,
        S_DATA   = 3'd3,
        S_STALL  = 3'd4,
        S_FINISH = 3'd5
    } state_e;

    localparam logic [7:0] READ_CMD = 8'h03;
    localparam int SH_W    = 8 + ADDR_W;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_MAX = (ADDR_W > 8) ? ADDR_W : 8;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BYTE_BITS = CNT_W'(8);
    localparam logic [CNT_W-1:0] ADDR_BITS = CNT_W'(ADDR_W);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(7);

    state_e            state_q;
    logic [DIV_W-1:0]  div_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic [SH_W-1:0]   tx_q;
    logic [7:0]        rx_q;
    logic [LEN_W-1:0]  rem_q;
    logic              pend_q;
    logic              last_q;
    logic              busy_q;
    logic              done_q;
    logic [7:0]        byte_data_q;
    logic              byte_valid_q;
    logic              cs_n_q;
    logic              sck_q;
    logic              mosi_q;

    logic tick;
    logic hs;

    assign tick = (div_q == DIV_LAST);
    assign hs   = byte_valid_q && byte_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            div_q        <= '0;
            bit_cnt_q    <= '0;
            tx_q         <= '0;
            rx_q         <= '0;
            rem_q        <= '0;
            pend_q       <= 1'b0;
            last_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            byte_data_q  <= '0;
            byte_valid_q <= 1'b0;
            cs_n_q       <= 1'b1;
            sck_q        <= 1'b0;
            mosi_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (hs) byte_valid_q <= 1'b0;
            // The byte captured on the previous rise is presented one clk later.
            if (pend_q) begin
                byte_data_q  <= rx_q;
                byte_valid_q <= 1'b1;
                rem_q        <= rem_q - LEN_W'(1);
                pend_q       <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (length != '0) begin
                            rem_q     <= length;
                            tx_q      <= {READ_CMD, start_addr};
                            mosi_q    <= READ_CMD[7];
                            cs_n_q    <= 1'b0;
                            div_q     <= '0;
                            bit_cnt_q <= '0;
                            busy_q    <= 1'b1;
                            state_q   <= S_CMD;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end

                S_CMD, S_ADDR, S_DATA: begin
                    div_q <= tick ? '0 : div_q + DIV_W'(1);
                    if (tick && !sck_q) begin
                        // An unconsumed byte blocks the first rise of the next one.
                        if (state_q == S_DATA && bit_cnt_q == '0 && byte_valid_q && !byte_ready) begin
                            state_q <= S_STALL;
                        end else begin
                            sck_q     <= 1'b1;
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                            rx_q      <= {rx_q[6:0], spi_miso};
                            if (state_q == S_DATA && bit_cnt_q == LAST_BIT) begin
                                pend_q <= 1'b1;
                                last_q <= (rem_q == LEN_W'(1));
                            end
                        end
                    end else if (tick) begin
                        sck_q  <= 1'b0;
                        tx_q   <= tx_q << 1;
                        mosi_q <= tx_q[SH_W-2];
                        if (state_q == S_CMD && bit_cnt_q == BYTE_BITS) begin
                            bit_cnt_q <= '0;
                            state_q   <= S_ADDR;
                        end
                        if (state_q == S_ADDR && bit_cnt_q == ADDR_BITS) begin
                            bit_cnt_q <= '0;
                            mosi_q    <= 1'b0;
                            state_q   <= S_DATA;
                        end
                        if (state_q == S_DATA) begin
                            mosi_q <= 1'b0;
                            if (bit_cnt_q == BYTE_BITS) begin
                                bit_cnt_q <= '0;
                                if (last_q) begin
                                    cs_n_q  <= 1'b1;
                                    state_q <= S_FINISH;
                                end
                            end
                        end
                    end
                end

                S_STALL: begin
                    if (hs) begin
                        div_q   <= '0;
                        state_q <= S_DATA;
                    end
                end

                S_FINISH: begin
                    // div_q restarted at the CS rise, so it doubles as the deselect timer.
                    if (div_q != DIV_LAST) begin
                        div_q <= div_q + DIV_W'(1);
                    end else if (!byte_valid_q) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign byte_data   = byte_data_q;
    assign byte_valid  = byte_valid_q;
    assign spi_cs_n    = cs_n_q;
    assign spi_sck     = sck_q;
    assign spi_mosi    = mosi_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: a behavioural READ-only flash on the SPI pins, a
// byte collector on the output side, and directed plus randomized transactions.
module tb_spi_flash_reader;

    localparam int CLK_DIV  = 2;
    localparam int ADDR_W   = 24;
    localparam int LEN_W    = 16;
    localparam int BYTE_CYC = 16 * CLK_DIV;

    logic              clk        = 1'b0;
    logic              rst_n      = 1'b1;
    logic              start      = 1'b0;
    logic [ADDR_W-1:0] start_addr = '0;
    logic [LEN_W-1:0]  length     = '0;
    logic              byte_ready = 1'b0;
    logic              spi_miso   = 1'b0;
    logic              busy;
    logic              done;
    logic [7:0]        byte_data;
    logic              byte_valid;
    logic              spi_cs_n;
    logic              spi_sck;
    logic              spi_mosi;
    logic [2:0]        dbg_state;

    int tests = 0;
    int fails = 0;

    spi_flash_reader #(
        .CLK_DIV(CLK_DIV),
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .length     (length),
        .busy       (busy),
        .done       (done),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .spi_cs_n   (spi_cs_n),
        .spi_sck    (spi_sck),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .dbg_state_o(dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, observed no summary, required $finish");
        $fatal(1, "watchdog");
    end

    // flash model: 256-byte array, header captured on SCK rises, data shifted out on falls
    logic [7:0]  flash_mem [256];
    int          fl_bits = 0;
    logic [31:0] fl_hdr  = '0;

    always @(posedge spi_sck or negedge spi_cs_n) begin
        if (!spi_sck) begin
            fl_bits = 0;
        end else if (!spi_cs_n) begin
            if (fl_bits < 32) fl_hdr = {fl_hdr[30:0], spi_mosi};
            fl_bits++;
        end
    end

    always @(negedge spi_sck) begin
        int k;
        logic [7:0] b;
        if (!spi_cs_n && fl_bits >= 32) begin
            k = fl_bits - 32;
            b = flash_mem[8'(fl_hdr[7:0] + 8'(k / 8))];
            spi_miso = b[7 - (k % 8)];
        end
    end

    // consumer: 0 = always ready, 1 = random ready, 2 = never ready
    int ready_mode = 0;
    always @(negedge clk) begin
        case (ready_mode)
            0:       byte_ready = 1'b1;
            1:       byte_ready = ($urandom_range(0, 3) != 0);
            default: byte_ready = 1'b0;
        endcase
    end

    // monitors (pre-edge samples)
    int         cyc        = 0;
    int         cs_low_cyc = 0;
    int         busy_cyc   = 0;
    int         done_cnt   = 0;
    int         done_fall  = 0;
    int         sck_rises  = 0;
    int         cs_falls   = 0;
    logic       busy_prev  = 1'b0;
    logic       valid_prev = 1'b0;
    logic [7:0] got_q[$];
    int         vrise_q[$];

    always @(posedge clk) begin
        cyc++;
        if (rst_n) begin
            if (!spi_cs_n) cs_low_cyc++;
            if (busy) busy_cyc++;
            if (done) done_cnt++;
            if (done && !busy && busy_prev) done_fall++;
            if (byte_valid && byte_ready) got_q.push_back(byte_data);
            if (byte_valid && !valid_prev) vrise_q.push_back(cyc);
        end
        busy_prev  = busy;
        valid_prev = byte_valid;
    end

    always @(posedge spi_sck) if (!spi_cs_n) sck_rises++;
    always @(negedge spi_cs_n) cs_falls++;

    // driver and checking tasks
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_txn(input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len);
        @(negedge clk);
        start_addr = addr;
        length     = len;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic wait_done(input int b_done, input int budget);
        int n = 0;
        while (done_cnt == b_done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_within_budget", 32'(done_cnt != b_done), 1);
    endtask

    task automatic run_txn(input logic [ADDR_W-1:0] addr, input int len, input bit poke);
        logic [7:0] exp_q[$];
        int b_sck, b_done, b_got, b_falls, b_fall;
        b_sck   = sck_rises;
        b_done  = done_cnt;
        b_got   = got_q.size();
        b_falls = cs_falls;
        b_fall  = done_fall;
        for (int i = 0; i < len; i++) exp_q.push_back(flash_mem[8'(addr[7:0] + 8'(i))]);
        start_txn(addr, LEN_W'(len));
        check("busy_after_start", 32'(busy), 1);
        if (poke) begin
            repeat (40) @(negedge clk);
            start_addr = ~addr;
            length     = LEN_W'(len + 3);
            start      = 1'b1;
            @(negedge clk);
            start      = 1'b0;
        end
        wait_done(b_done, 20000);
        repeat (3) @(negedge clk);
        check("byte_count", got_q.size() - b_got, len);
        for (int i = 0; i < len && b_got + i < got_q.size(); i++)
            check("byte_data", 32'(got_q[b_got + i]), 32'(exp_q[i]));
        check("sck_rises", sck_rises - b_sck, 32 + 8 * len);
        check("cs_windows", cs_falls - b_falls, 1);
        check("done_pulses", done_cnt - b_done, 1);
        check("busy_falls_with_done", done_fall - b_fall, 1);
        check("mosi_header", fl_hdr, {8'h03, addr});
        check("cs_idle_after", 32'(spi_cs_n), 1);
    endtask

    // directed steps
    initial begin
        logic [7:0]        exp_q[$];
        logic [ADDR_W-1:0] addr;
        int b_cs, b_vr, b_sck, b_got, b_done, b_falls, b_busy, s0, n;

        for (int i = 0; i < 256; i++) flash_mem[i] = 8'($urandom);
        flash_mem[8'h10] = 8'hA5;
        flash_mem[0] = 8'h11;
        flash_mem[1] = 8'h22;
        flash_mem[2] = 8'h33;
        flash_mem[3] = 8'h44;

        // reset
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cs_n", 32'(spi_cs_n), 1);
        check("rst_sck", 32'(spi_sck), 0);
        check("rst_mosi", 32'(spi_mosi), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_valid", 32'(byte_valid), 0);
        check("rst_data", 32'(byte_data), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_cs_n", 32'(spi_cs_n), 1);

        // single byte at 0x10
        b_cs = cs_low_cyc;
        b_vr = vrise_q.size();
        run_txn(24'h000010, 1, 1'b0);
        check("t1_cs_low_cycles", cs_low_cyc - b_cs, 40 * 2 * CLK_DIV);
        check("t1_valid_pulses", vrise_q.size() - b_vr, 1);

        // four bytes back to back
        b_cs = cs_low_cyc;
        b_vr = vrise_q.size();
        run_txn(24'h000000, 4, 1'b0);
        check("t2_cs_low_cycles", cs_low_cyc - b_cs, 64 * 2 * CLK_DIV);
        check("t2_valid_pulses", vrise_q.size() - b_vr, 4);
        for (int i = 1; i < 4 && b_vr + i < vrise_q.size(); i++)
            check("t2_byte_interval", vrise_q[b_vr + i] - vrise_q[b_vr + i - 1], BYTE_CYC);

        // consumer stalls after the first byte
        ready_mode = 2;
        @(negedge clk);
        addr    = ADDR_W'($urandom);
        b_sck   = sck_rises;
        b_got   = got_q.size();
        b_done  = done_cnt;
        exp_q.delete();
        for (int i = 0; i < 3; i++) exp_q.push_back(flash_mem[8'(addr[7:0] + 8'(i))]);
        start_txn(addr, 3);
        n = 0;
        while (!byte_valid && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("t3_first_byte_seen", 32'(byte_valid), 1);
        check("t3_first_byte", 32'(byte_data), 32'(exp_q[0]));
        repeat (4) @(negedge clk);
        s0 = sck_rises;
        repeat (46) @(negedge clk);
        check("t3_no_sck_in_stall", sck_rises - s0, 0);
        check("t3_sck_low", 32'(spi_sck), 0);
        check("t3_cs_held", 32'(spi_cs_n), 0);
        check("t3_data_stable", 32'(byte_data), 32'(exp_q[0]));
        check("t3_valid_held", 32'(byte_valid), 1);
        ready_mode = 0;
        wait_done(b_done, 20000);
        repeat (3) @(negedge clk);
        check("t3_bytes", got_q.size() - b_got, 3);
        for (int i = 0; i < 3 && b_got + i < got_q.size(); i++)
            check("t3_byte_data", 32'(got_q[b_got + i]), 32'(exp_q[i]));
        check("t3_sck_total", sck_rises - b_sck, 56);
        check("t3_done", done_cnt - b_done, 1);

        // zero length
        b_done  = done_cnt;
        b_sck   = sck_rises;
        b_falls = cs_falls;
        b_busy  = busy_cyc;
        start_txn(ADDR_W'($urandom), '0);
        check("t4_done_next_cycle", 32'(done), 1);
        check("t4_busy_low", 32'(busy), 0);
        @(negedge clk);
        check("t4_done_single", 32'(done), 0);
        repeat (5) @(negedge clk);
        check("t4_no_cs", cs_falls - b_falls, 0);
        check("t4_no_sck", sck_rises - b_sck, 0);
        check("t4_busy_never", busy_cyc - b_busy, 0);
        check("t4_done_count", done_cnt - b_done, 1);

        // reset during the address phase
        b_done = done_cnt;
        b_got  = got_q.size();
        start_txn(ADDR_W'($urandom), 2);
        repeat (60) @(negedge clk);
        check("t5_in_txn_cs", 32'(spi_cs_n), 0);
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_cs_n", 32'(spi_cs_n), 1);
        check("t5_async_sck", 32'(spi_sck), 0);
        check("t5_async_valid", 32'(byte_valid), 0);
        check("t5_async_busy", 32'(busy), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("t5_no_done", done_cnt - b_done, 0);
        check("t5_no_bytes", got_q.size() - b_got, 0);
        run_txn(ADDR_W'($urandom), 2, 1'b0);

        // start pulsed while busy
        run_txn(ADDR_W'($urandom), 2, 1'b1);

        // randomized lengths, addresses and consumer back-pressure
        ready_mode = 1;
        for (int t = 0; t < 6; t++) run_txn(ADDR_W'($urandom), $urandom_range(1, 6), 1'b0);
        ready_mode = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
